// File: rtl/blockram_true_dual_port_if.sv
// Bus bundle for the true dual-port block RAM: per-port access controls,
// read responses and the shared status flags.
interface blockram_true_dual_port_if #(
    parameter int RAM_WIDTH  = 16,
    parameter int RAM_DEPTH  = 1024,
    parameter int BYTE_WIDTH = 8
);
    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int NB = RAM_WIDTH / BYTE_WIDTH;

    logic                 en_a;
    logic [NB-1:0]        we_a;
    logic [AW-1:0]        addr_a;
    logic [RAM_WIDTH-1:0] din_a;
    logic [RAM_WIDTH-1:0] dout_a;
    logic                 valid_a;

    logic                 en_b;
    logic [NB-1:0]        we_b;
    logic [AW-1:0]        addr_b;
    logic [RAM_WIDTH-1:0] din_b;
    logic [RAM_WIDTH-1:0] dout_b;
    logic                 valid_b;

    logic                 collision;
    logic                 init_done;

    modport master (
        output en_a, we_a, addr_a, din_a,
        output en_b, we_b, addr_b, din_b,
        input  dout_a, valid_a, dout_b, valid_b, collision, init_done
    );

    modport slave (
        input  en_a, we_a, addr_a, din_a,
        input  en_b, we_b, addr_b, din_b,
        output dout_a, valid_a, dout_b, valid_b, collision, init_done
    );
endinterface

// File: rtl/blockram_true_dual_port.sv
// True dual-port block RAM with byte-lane writes, selectable write mode,
// 1- or 2-cycle read latency, same-address collision flag and a zeroing
// sweep that runs after every reset before the ports are accepted.
module blockram_true_dual_port #(
    parameter int    RAM_WIDTH    = 16,
    parameter int    RAM_DEPTH    = 1024,
    parameter int    BYTE_WIDTH   = 8,
    parameter int    READ_LATENCY = 1,
    parameter string WRITE_MODE   = "READ_FIRST"
) (
    input logic                      clk,
    input logic                      rst_n,
    blockram_true_dual_port_if.slave bus
);
    localparam int AW      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int NB      = RAM_WIDTH / BYTE_WIDTH;
    localparam bit MODE_RF = (WRITE_MODE == "READ_FIRST");
    localparam bit MODE_WF = (WRITE_MODE == "WRITE_FIRST");
    localparam bit MODE_NC = (WRITE_MODE == "NO_CHANGE");

    if (RAM_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("RAM_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if (!(MODE_RF || MODE_WF || MODE_NC)) begin : g_bad_mode
        $error("WRITE_MODE must be READ_FIRST, WRITE_FIRST or NO_CHANGE");
    end

    // Overlay the enabled byte lanes of din onto base.
    function automatic logic [RAM_WIDTH-1:0] merge_lanes(
        input logic [RAM_WIDTH-1:0] base,
        input logic [RAM_WIDTH-1:0] din,
        input logic [NB-1:0]        lanes
    );
        logic [RAM_WIDTH-1:0] res;
        res = base;
        for (int i = 0; i < NB; i++) begin
            if (lanes[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        return res;
    endfunction

    typedef enum logic {INIT, READY} state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  sweep_addr, sweep_nxt;
    logic           ready;

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    logic                 acc_a, acc_b, wr_a, wr_b, inr_a, inr_b, same_addr;
    logic                 due_a, due_b, coll;
    logic [RAM_WIDTH-1:0] old_a, old_b, wdata_a, wdata_b, rdata_a, rdata_b;
    logic [RAM_WIDTH-1:0] rsp_data_a, rsp_data_b;
    logic                 rsp_vld_a, rsp_vld_b;

    // Init FSM and sweep counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            sweep_addr <= '0;
        end else begin
            state      <= state_nxt;
            sweep_addr <= sweep_nxt;
        end
    end

    // Sweep one address per cycle; leave INIT after the last word is cleared.
    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep_addr;
        if (state == INIT) begin
            sweep_nxt = sweep_addr + AW'(1);
            if (sweep_addr == AW'(RAM_DEPTH - 1)) state_nxt = READY;
        end
    end

    assign ready     = (state == READY);
    assign acc_a     = ready && bus.en_a;
    assign acc_b     = ready && bus.en_b;
    assign wr_a      = acc_a && (|bus.we_a);
    assign wr_b      = acc_b && (|bus.we_b);
    assign inr_a     = ({1'b0, bus.addr_a} < (AW+1)'(RAM_DEPTH));
    assign inr_b     = ({1'b0, bus.addr_b} < (AW+1)'(RAM_DEPTH));
    assign same_addr = (bus.addr_a == bus.addr_b);
    assign old_a     = inr_a ? mem[bus.addr_a] : '0;
    assign old_b     = inr_b ? mem[bus.addr_b] : '0;

    // Port A is applied on top of port B's lanes so A wins shared lanes on a tie.
    assign wdata_b = merge_lanes(old_b, bus.din_b, bus.we_b);
    assign wdata_a = merge_lanes(merge_lanes(old_a, bus.din_b, (same_addr && wr_b) ? bus.we_b : '0),
                                 bus.din_a, bus.we_a);

    // Response words: out-of-range reads return zero; only WRITE_FIRST shows the write.
    assign rdata_a = !inr_a ? '0 : (wr_a && MODE_WF) ? merge_lanes(old_a, bus.din_a, bus.we_a) : old_a;
    assign rdata_b = !inr_b ? '0 : (wr_b && MODE_WF) ? merge_lanes(old_b, bus.din_b, bus.we_b) : old_b;
    assign due_a   = acc_a && !(wr_a && MODE_NC);
    assign due_b   = acc_b && !(wr_b && MODE_NC);
    assign coll    = acc_a && acc_b && same_addr && (wr_a || wr_b);

    // Memory array: sweep writes zeros in INIT, port writes in READY; never reset.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[sweep_addr] <= '0;
        end else begin
            if (wr_b && inr_b) mem[bus.addr_b] <= wdata_b;
            if (wr_a && inr_a) mem[bus.addr_a] <= wdata_a;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [RAM_WIDTH-1:0] data_a_p0, data_b_p0;
        logic                 vld_a_p0, vld_b_p0;

        // Stage p0: response-due flags, cleared by reset to drop in-flight reads.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_a_p0 <= 1'b0;
                vld_b_p0 <= 1'b0;
            end else begin
                vld_a_p0 <= due_a;
                vld_b_p0 <= due_b;
            end
        end

        // Stage p0: response data, qualified by the p0 valid flags.
        always_ff @(posedge clk) begin
            data_a_p0 <= rdata_a;
            data_b_p0 <= rdata_b;
        end

        assign rsp_data_a = data_a_p0;
        assign rsp_data_b = data_b_p0;
        assign rsp_vld_a  = vld_a_p0;
        assign rsp_vld_b  = vld_b_p0;
    end else begin : g_lat1
        assign rsp_data_a = rdata_a;
        assign rsp_data_b = rdata_b;
        assign rsp_vld_a  = due_a;
        assign rsp_vld_b  = due_b;
    end

    // Output stage: dout updates only with a response, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout_a    <= '0;
            bus.dout_b    <= '0;
            bus.valid_a   <= 1'b0;
            bus.valid_b   <= 1'b0;
            bus.collision <= 1'b0;
            bus.init_done <= 1'b0;
        end else begin
            bus.valid_a   <= rsp_vld_a;
            bus.valid_b   <= rsp_vld_b;
            bus.collision <= coll;
            bus.init_done <= ready;
            if (rsp_vld_a) bus.dout_a <= rsp_data_a;
            if (rsp_vld_b) bus.dout_b <= rsp_data_b;
        end
    end
endmodule

// File: tb/tb_blockram_true_dual_port.sv
// Scoreboard bench: three RAM configurations share one stimulus stream; a
// reference memory per configuration predicts responses into queues that
// are drained as the DUT outputs appear.
module tb_blockram_true_dual_port;
    localparam int NDUT = 3;
    localparam int LAT       [NDUT] = '{1, 2, 1};
    localparam int DEPTH     [NDUT] = '{1024, 1024, 1000};
    localparam int MODE      [NDUT] = '{0, 1, 2};          // 0 read-first, 1 write-first, 2 no-change
    localparam int INIT_RISE [NDUT] = '{1025, 1025, 1001};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        s_en_a = 1'b0, s_en_b = 1'b0;
    logic [1:0]  s_we_a = '0, s_we_b = '0;
    logic [9:0]  s_addr_a = '0, s_addr_b = '0;
    logic [15:0] s_din_a = '0, s_din_b = '0;

    logic [15:0] o_dout_a  [NDUT];
    logic [15:0] o_dout_b  [NDUT];
    logic        o_valid_a [NDUT];
    logic        o_valid_b [NDUT];
    logic        o_coll    [NDUT];
    logic        o_init    [NDUT];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit model_on = 1'b0;
    bit mon_on = 1'b0;

    typedef struct { int due; logic [15:0] data; } rsp_t;
    rsp_t        sbq [2*NDUT][$];
    logic [15:0] mdl [NDUT][1024];
    logic [15:0] last_dout [2*NDUT];
    bit          coll_exp [NDUT];
    string       dname [NDUT] = '{"rf", "wf", "nc"};

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        blockram_true_dual_port_if #(.RAM_WIDTH(16), .RAM_DEPTH(1024), .BYTE_WIDTH(8)) bus_if ();
        assign bus_if.en_a   = s_en_a;
        assign bus_if.we_a   = s_we_a;
        assign bus_if.addr_a = s_addr_a;
        assign bus_if.din_a  = s_din_a;
        assign bus_if.en_b   = s_en_b;
        assign bus_if.we_b   = s_we_b;
        assign bus_if.addr_b = s_addr_b;
        assign bus_if.din_b  = s_din_b;
        assign o_dout_a[g]   = bus_if.dout_a;
        assign o_dout_b[g]   = bus_if.dout_b;
        assign o_valid_a[g]  = bus_if.valid_a;
        assign o_valid_b[g]  = bus_if.valid_b;
        assign o_coll[g]     = bus_if.collision;
        assign o_init[g]     = bus_if.init_done;
        if (g == 0) begin : g_rf
            blockram_true_dual_port #(.RAM_WIDTH(16), .RAM_DEPTH(1024), .BYTE_WIDTH(8),
                .READ_LATENCY(1), .WRITE_MODE("READ_FIRST")) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));
        end else if (g == 1) begin : g_wf
            blockram_true_dual_port #(.RAM_WIDTH(16), .RAM_DEPTH(1024), .BYTE_WIDTH(8),
                .READ_LATENCY(2), .WRITE_MODE("WRITE_FIRST")) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));
        end else begin : g_nc
            blockram_true_dual_port #(.RAM_WIDTH(16), .RAM_DEPTH(1000), .BYTE_WIDTH(8),
                .READ_LATENCY(1), .WRITE_MODE("NO_CHANGE")) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Reference model: evaluates each access at the clock edge that samples it.
    always @(posedge clk) begin
        bit          inr_a, inr_b, wr_a, wr_b;
        logic [15:0] old_a, old_b, r;
        rsp_t        e;
        for (int d = 0; d < NDUT; d++) begin
            coll_exp[d] = 1'b0;
            if (model_on) begin
                inr_a = int'(s_addr_a) < DEPTH[d];
                inr_b = int'(s_addr_b) < DEPTH[d];
                old_a = inr_a ? mdl[d][s_addr_a] : 16'h0;
                old_b = inr_b ? mdl[d][s_addr_b] : 16'h0;
                wr_a  = s_en_a && (s_we_a != 2'b00);
                wr_b  = s_en_b && (s_we_b != 2'b00);
                if (s_en_a && !(wr_a && MODE[d] == 2)) begin
                    r = old_a;
                    if (wr_a && MODE[d] == 1 && inr_a)
                        for (int l = 0; l < 2; l++) if (s_we_a[l]) r[l*8 +: 8] = s_din_a[l*8 +: 8];
                    e.due = cyc + LAT[d];
                    e.data = r;
                    sbq[2*d].push_back(e);
                end
                if (s_en_b && !(wr_b && MODE[d] == 2)) begin
                    r = old_b;
                    if (wr_b && MODE[d] == 1 && inr_b)
                        for (int l = 0; l < 2; l++) if (s_we_b[l]) r[l*8 +: 8] = s_din_b[l*8 +: 8];
                    e.due = cyc + LAT[d];
                    e.data = r;
                    sbq[2*d+1].push_back(e);
                end
                if (wr_b && inr_b)
                    for (int l = 0; l < 2; l++) if (s_we_b[l]) mdl[d][s_addr_b][l*8 +: 8] = s_din_b[l*8 +: 8];
                if (wr_a && inr_a)
                    for (int l = 0; l < 2; l++) if (s_we_a[l]) mdl[d][s_addr_a][l*8 +: 8] = s_din_a[l*8 +: 8];
                coll_exp[d] = s_en_a && s_en_b && (s_addr_a == s_addr_b) && (wr_a || wr_b);
            end
        end
        cyc <= cyc + 1;
    end

    // Monitor: every cycle check valid, dout (new or held) and collision.
    always @(negedge clk) begin
        int          k;
        bit          ev;
        logic        vact;
        logic [15:0] dact;
        if (mon_on) begin
            for (int d = 0; d < NDUT; d++) begin
                for (int p = 0; p < 2; p++) begin
                    k = 2*d + p;
                    vact = (p == 1) ? o_valid_b[d] : o_valid_a[d];
                    dact = (p == 1) ? o_dout_b[d] : o_dout_a[d];
                    ev = (sbq[k].size() != 0) && (sbq[k][0].due == cyc);
                    if (ev) begin
                        last_dout[k] = sbq[k][0].data;
                        void'(sbq[k].pop_front());
                    end
                    chk($sformatf("%s valid_%s @%0d", dname[d], (p == 1) ? "b" : "a", cyc), 32'(vact), 32'(ev));
                    chk($sformatf("%s dout_%s @%0d", dname[d], (p == 1) ? "b" : "a", cyc), 32'(dact), 32'(last_dout[k]));
                end
                chk($sformatf("%s collision @%0d", dname[d], cyc), 32'(o_coll[d]), 32'(coll_exp[d]));
            end
        end
    end

    task automatic acc(input logic ea, input logic [1:0] wa, input logic [9:0] aa, input logic [15:0] da,
                       input logic eb, input logic [1:0] wb, input logic [9:0] ab, input logic [15:0] db);
        s_en_a = ea; s_we_a = wa; s_addr_a = aa; s_din_a = da;
        s_en_b = eb; s_we_b = wb; s_addr_b = ab; s_din_b = db;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        s_en_a = 1'b0; s_we_a = '0; s_en_b = 1'b0; s_we_b = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string when);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s %s dout_a", dname[d], when), 32'(o_dout_a[d]), 32'h0);
            chk($sformatf("%s %s dout_b", dname[d], when), 32'(o_dout_b[d]), 32'h0);
            chk($sformatf("%s %s valid", dname[d], when), {30'b0, o_valid_a[d], o_valid_b[d]}, 32'h0);
            chk($sformatf("%s %s coll/init", dname[d], when), {30'b0, o_coll[d], o_init[d]}, 32'h0);
        end
    endtask

    initial begin
        int rise [NDUT];
        bit bad_vld [NDUT];
        for (int d = 0; d < NDUT; d++) begin
            for (int a = 0; a < 1024; a++) mdl[d][a] = 16'h0;
            rise[d] = 0;
            bad_vld[d] = 1'b0;
        end
        for (int k = 0; k < 2*NDUT; k++) last_dout[k] = 16'h0;

        repeat (3) @(negedge clk);
        chk_all_zero("in reset");

        // First sweep, with accesses attempted, interrupted at sweep address 500.
        rst_n = 1'b1;
        s_en_a = 1'b1; s_we_a = 2'b11; s_addr_a = 10'd5; s_din_a = 16'hFFFF;
        s_en_b = 1'b1; s_addr_b = 10'd5;
        repeat (500) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset mid-sweep");
        @(negedge clk);
        rst_n = 1'b1;

        // Restarted sweep: init_done must take the full depth plus one cycle.
        for (int n = 1; n <= 1100; n++) begin
            @(negedge clk);
            if (n == 900) idle(0);
            for (int d = 0; d < NDUT; d++) begin
                if (o_init[d] && rise[d] == 0) rise[d] = n;
                if (o_valid_a[d] || o_valid_b[d]) bad_vld[d] = 1'b1;
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s init_done rise cycle", dname[d]), 32'(rise[d]), 32'(INIT_RISE[d]));
            chk($sformatf("%s valid during sweep", dname[d]), 32'(bad_vld[d]), 32'h0);
        end

        model_on = 1'b1;
        mon_on = 1'b1;
        acc(1, 2'b00, 10'h005, 16'h0, 1, 2'b00, 10'h123, 16'h0);
        acc(1, 2'b00, 10'h3FF, 16'h0, 0, 2'b00, 10'h000, 16'h0);
        acc(1, 2'b11, 10'h010, 16'hBEEF, 0, 2'b00, 10'h000, 16'h0);
        acc(0, 2'b00, 10'h000, 16'h0, 1, 2'b00, 10'h010, 16'h0);
        acc(1, 2'b11, 10'h020, 16'h1234, 0, 2'b00, 10'h000, 16'h0);
        acc(1, 2'b01, 10'h020, 16'hABCD, 0, 2'b00, 10'h000, 16'h0);
        acc(1, 2'b00, 10'h020, 16'h0, 1, 2'b00, 10'h020, 16'h0);
        acc(1, 2'b01, 10'h030, 16'h1111, 1, 2'b11, 10'h030, 16'h2222);
        acc(1, 2'b00, 10'h030, 16'h0, 0, 2'b00, 10'h000, 16'h0);
        acc(1, 2'b11, 10'h040, 16'h5555, 1, 2'b00, 10'h040, 16'h0);
        acc(0, 2'b00, 10'h000, 16'h0, 1, 2'b00, 10'h040, 16'h0);
        for (int i = 0; i < 4; i++) acc(1, 2'b11, 10'(i), 16'h1000 + 16'(i * 257), 0, 2'b00, 10'h000, 16'h0);
        for (int i = 0; i < 4; i++) acc(0, 2'b00, 10'h000, 16'h0, 1, 2'b00, 10'(i), 16'h0);
        acc(1, 2'b11, 10'h3F0, 16'h7777, 0, 2'b00, 10'h000, 16'h0);
        acc(1, 2'b00, 10'h3F0, 16'h0, 1, 2'b00, 10'd1000, 16'h0);
        for (int i = 0; i < 40; i++) begin
            acc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 7)) : 10'(1000 + $urandom_range(0, 7)),
                16'($urandom),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 7)) : 10'(1000 + $urandom_range(0, 7)),
                16'($urandom));
        end
        idle(4);
        for (int k = 0; k < 2*NDUT; k++) chk($sformatf("drain queue %0d", k), 32'(sbq[k].size()), 32'h0);
        mon_on = 1'b0;
        model_on = 1'b0;

        // Reset during operation: outputs clear at once and in-flight reads vanish.
        acc(1, 2'b00, 10'h010, 16'h0, 0, 2'b00, 10'h000, 16'h0);
        idle(0);
        chk("rf dout_a before reset", 32'(o_dout_a[0]), 32'hBEEF);
        chk("rf valid_a before reset", 32'(o_valid_a[0]), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset mid-operation");
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++)
                chk($sformatf("%s after reset valid/init", dname[d]),
                    {29'b0, o_valid_a[d], o_valid_b[d], o_init[d]}, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/blockram_true_dual_port.md
BLOCKRAM_TRUE_DUAL_PORT -- requirements
Module: blockram_true_dual_port

Interface
REQ-001 Parameter RAM_WIDTH, default 16: data word width in bits.
REQ-002 Parameter RAM_DEPTH, default 1024: number of words; AW = $clog2(RAM_DEPTH).
REQ-003 Parameter BYTE_WIDTH, default 8: write-lane width; NB = RAM_WIDTH/BYTE_WIDTH.
REQ-004 Parameter READ_LATENCY, default 1: legal values 1 or 2 cycles.
REQ-005 Parameter WRITE_MODE, default "READ_FIRST": legal values "READ_FIRST", "WRITE_FIRST", "NO_CHANGE"; applies to both ports.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock for all logic.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 en_a / en_b  in  1  port access enable.
REQ-010 we_a / we_b  in  NB  per-lane write enable; nonzero with en set means write access.
REQ-011 addr_a / addr_b  in  AW  word address.
REQ-012 din_a / din_b  in  RAM_WIDTH  write data.
REQ-013 dout_a / dout_b  out  RAM_WIDTH  read data.
REQ-014 valid_a / valid_b  out  1  one-cycle pulse, dout of that port is new this cycle.
REQ-015 collision  out  1  one-cycle pulse flagging a same-address conflict.
REQ-016 init_done  out  1  high once the memory-clear sweep has completed.

Function
REQ-017 The block SHALL elaborate to an error if RAM_WIDTH % BYTE_WIDTH != 0, READ_LATENCY is not 1 or 2, or WRITE_MODE is illegal.
REQ-018 The init FSM SHALL have states INIT and READY; reset enters INIT with sweep counter 0.
REQ-019 In INIT the block SHALL write zero to one address per cycle, 0 through RAM_DEPTH-1, ignoring en_a/en_b and holding valid_a/valid_b low.
REQ-020 After writing address RAM_DEPTH-1 the FSM SHALL enter READY, with init_done high on the next cycle; total sweep is RAM_DEPTH cycles; READY has no exit except reset.
REQ-021 In READY, a write SHALL update only lanes i where we_x[i]=1, with bits [i*BYTE_WIDTH +: BYTE_WIDTH] from din_x.
REQ-022 A read (en=1, we=0) SHALL present the addressed word on dout_x with valid_x high exactly READ_LATENCY cycles after the enabling edge.
REQ-023 A write access SHALL produce a read response: READ_FIRST gives the old word; WRITE_FIRST gives the merged new word (old contents in disabled lanes); NO_CHANGE gives no response, valid stays low and dout holds.
REQ-024 dout_x SHALL hold its last value whenever no response is due; when READ_LATENCY=2, back-to-back accesses SHALL sustain one response per cycle.
REQ-025 If both ports are enabled, addresses are equal and at least one port writes, collision SHALL pulse high the cycle after the access edge.
REQ-026 If both ports write the same address, port A data SHALL win on lanes enabled by both; each port's remaining enabled lanes SHALL be written.
REQ-027 If one port reads and the other writes the same address, the reading port SHALL return the old word regardless of WRITE_MODE.
REQ-028 If RAM_DEPTH is not a power of two, an address >= RAM_DEPTH SHALL have its write ignored and its read return zero, with normal valid timing.

Reset
REQ-029 rst_n low SHALL immediately force dout_a, dout_b, valid_a, valid_b, collision and init_done to 0, clear the read pipeline, and set the FSM to INIT.
REQ-030 Memory contents SHALL NOT be reset directly; the sweep SHALL clear them after rst_n deasserts.
REQ-031 Reset asserted mid-sweep or mid-operation SHALL discard in-flight responses and restart the sweep from address 0.

Verification
REQ-032 Release reset, DEPTH=1024 -> init_done rises 1025 cycles after release; read any address -> 0x0000.
REQ-033 READY, READ_LATENCY=1: A writes 0xBEEF to 0x010 with we_a=2'b11; next cycle B reads 0x010 -> dout_b=0xBEEF, valid_b high one cycle later.
REQ-034 Word 0x1234 at 0x020; A writes 0xABCD with we_a=2'b01 -> READ_FIRST dout_a=0x1234; WRITE_FIRST dout_a=0x12CD; NO_CHANGE valid_a stays 0; memory ends 0x12CD.
REQ-035 Same edge, addr 0x030: A writes 0x1111 we=2'b01, B writes 0x2222 we=2'b11 -> collision pulses once; memory holds 0x2211.
REQ-036 READ_LATENCY=2, B reads 0x000..0x003 on consecutive cycles -> four consecutive valid_b pulses with correct data, starting 2 cycles after first access.
REQ-037 Assert rst_n low at sweep address 500 -> outputs 0 at once; after release, sweep restarts at 0 and init_done rises after full RAM_DEPTH cycles.
